// File: rtl/mat_mult_seq.sv
// rtl/mat_mult_seq.sv - sequential N x N matrix multiplier with a single MAC and bus read-back of C
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   a_all      flattened A, element (r,c) at [BITS*(r*N+c) +: BITS]
//   b_all      flattened B, same layout
//   start      request computation (sampled in IDLE only)
//   busy       high while computing (N^3 cycles)
//   done       one-cycle pulse when C is complete
//   res_valid  C complete and stable
//   rd_en      bus read strobe
//   rd_addr    bus byte address
//   rd_data    registered element read back, zero-extended
//   rd_hit     previous-cycle read was inside the result window
//   c_all      flattened C, element (r,c) at [OUT_BITS*(r*N+c) +: OUT_BITS]
module mat_mult_seq #(
    parameter int BITS       = 8,
    parameter int N          = 8,
    parameter int OUT_BITS   = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int OFFSET     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*N*BITS-1:0]        a_all,
    input  logic [N*N*BITS-1:0]        b_all,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [31:0]                rd_data,
    output logic                       rd_hit,
    output logic [N*N*OUT_BITS-1:0]    c_all
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (N > 1) ? $clog2(N * N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [N*N*BITS-1:0]    a_snap;
    logic [N*N*BITS-1:0]    b_snap;
    logic [CW-1:0]          i;
    logic [CW-1:0]          j;
    logic [CW-1:0]          k;
    logic [OUT_BITS-1:0]    acc;
    logic [OUT_BITS-1:0]    acc_n;
    logic [OUT_BITS-1:0]    c_mem [N*N];
    logic [BITS-1:0]        a_el;
    logic [BITS-1:0]        b_el;
    logic [2*BITS-1:0]      prod;
    logic                   last_i;
    logic                   last_j;
    logic                   last_k;
    logic [IW-1:0]          wr_idx;
    logic [IW-1:0]          rd_idx;
    logic                   rd_in_range;

    // MAC datapath: k==0 starts a fresh dot product, so the accumulator
    // never needs a separate clear cycle between output elements.
    always_comb begin
        a_el   = a_snap[BITS*(int'(i)*N + int'(k)) +: BITS];
        b_el   = b_snap[BITS*(int'(k)*N + int'(j)) +: BITS];
        prod   = a_el * b_el;
        acc_n  = ((k == '0) ? '0 : acc) + OUT_BITS'(prod);
        wr_idx = IW'(int'(i)*N + int'(j));
        last_i = (i == CW'(N - 1));
        last_j = (j == CW'(N - 1));
        last_k = (k == CW'(N - 1));
    end

    // Range check done in 32 bits so the window end may exceed the bus width.
    always_comb begin
        rd_in_range = rd_en
                   && (32'(rd_addr) >= 32'(OFFSET))
                   && (32'(rd_addr) <  32'(OFFSET + 4*N*N));
        rd_idx      = IW'((32'(rd_addr) - 32'(OFFSET)) >> 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            a_snap    <= '0;
            b_snap    <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            for (int e = 0; e < N*N; e++) begin
                c_mem[e] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_snap    <= a_all;
                        b_snap    <= b_all;
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        res_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    if (last_k) begin
                        c_mem[wr_idx] <= acc_n;
                        k <= '0;
                        if (last_j) begin
                            j <= '0;
                            if (last_i) begin
                                i         <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                res_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                i <= i + CW'(1);
                            end
                        end else begin
                            j <= j + CW'(1);
                        end
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
        end else begin
            rd_hit  <= rd_in_range;
            rd_data <= rd_in_range ? 32'(c_mem[rd_idx]) : '0;
        end
    end

    for (genvar e = 0; e < N*N; e++) begin : g_c_all
        assign c_all[OUT_BITS*e +: OUT_BITS] = c_mem[e];
    end

endmodule

// File: tb/tb_mat_mult_seq.sv
// tb/tb_mat_mult_seq.sv - self-checking bench for mat_mult_seq (N=2 windowed instance and N=8 instance)
module tb_mat_mult_seq;

    logic           clk;
    logic           rst;

    logic [31:0]    a2;
    logic [31:0]    b2;
    logic           start2;
    logic           busy2;
    logic           done2;
    logic           rv2;
    logic           rd_en2;
    logic [9:0]     rd_addr2;
    logic [31:0]    rd_data2;
    logic           rd_hit2;
    logic [127:0]   c2;

    logic [511:0]   a8;
    logic [511:0]   b8;
    logic           start8;
    logic           busy8;
    logic           done8;
    logic           rv8;
    logic           rd_en8;
    logic [9:0]     rd_addr8;
    logic [31:0]    rd_data8;
    logic           rd_hit8;
    logic [2047:0]  c8;

    int vectors;
    int errs;

    mat_mult_seq #(.BITS(8), .N(2), .OUT_BITS(32), .ADDR_WIDTH(10), .OFFSET(256)) u_dut2 (
        .clk(clk), .rst(rst), .a_all(a2), .b_all(b2), .start(start2),
        .busy(busy2), .done(done2), .res_valid(rv2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_hit(rd_hit2),
        .c_all(c2)
    );

    mat_mult_seq #(.BITS(8), .N(8), .OUT_BITS(32), .ADDR_WIDTH(10), .OFFSET(0)) u_dut8 (
        .clk(clk), .rst(rst), .a_all(a8), .b_all(b8), .start(start8),
        .busy(busy8), .done(done8), .res_valid(rv8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8), .rd_hit(rd_hit8),
        .c_all(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain dot products of the row of A and column of B.
    function automatic logic [31:0] mref(input logic [511:0] a, input logic [511:0] b,
                                         input int n, input int r, input int c);
        logic [31:0] s;
        s = 0;
        for (int kk = 0; kk < n; kk++) begin
            s += 32'(a[8*(r*n+kk) +: 8]) * 32'(b[8*(kk*n+c) +: 8]);
        end
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the done pulse.
    task automatic run2(input logic [31:0] a, input logic [31:0] b, input bit disturb);
        int cnt;
        int bc;
        int dc;
        a2 = a;
        b2 = b;
        start2 = 1'b1;
        cnt = 0;
        bc = 0;
        dc = 0;
        while (dc == 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start2 = 1'b0;
                chk("rv2_cleared", rv2, 0);
                if (disturb) a2 = '0;
            end
            if (disturb && cnt == 3) start2 = 1'b1;
            if (disturb && cnt == 4) start2 = 1'b0;
            if (busy2) bc++;
            if (done2) dc = cnt;
        end
        chk("busy2_cycles", bc, 8);
        chk("done2_cycle", dc, 9);
        chk("rv2_at_done", rv2, 1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("c2[%0d][%0d]", r, c), c2[32*(r*2+c) +: 32],
                    mref({480'd0, a}, {480'd0, b}, 2, r, c));
            end
        end
        @(negedge clk);
        chk("done2_one_cycle", done2, 0);
        chk("rv2_held", rv2, 1);
        chk("busy2_after", busy2, 0);
    endtask

    task automatic run8(input logic [511:0] a, input logic [511:0] b);
        int cnt;
        int bc;
        int dc;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        cnt = 0;
        bc = 0;
        dc = 0;
        while (dc == 0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start8 = 1'b0;
            if (busy8) bc++;
            if (done8) dc = cnt;
        end
        chk("busy8_cycles", bc, 512);
        chk("done8_cycle", dc, 513);
        chk("rv8_at_done", rv8, 1);
        @(negedge clk);
    endtask

    task automatic rd2(input logic [9:0] addr, input bit en, input logic [31:0] exp_d,
                       input bit exp_h, input string tag);
        rd_en2 = en;
        rd_addr2 = addr;
        @(negedge clk);
        rd_en2 = 1'b0;
        chk({tag, "_data"}, rd_data2, exp_d);
        chk({tag, "_hit"}, rd_hit2, exp_h);
    endtask

    initial begin
        logic [511:0] ra;
        logic [511:0] rb;
        int pulses;
        vectors = 0;
        errs = 0;
        rst = 1'b0;
        a2 = '0; b2 = '0; start2 = 1'b0; rd_en2 = 1'b0; rd_addr2 = '0;
        a8 = '0; b8 = '0; start8 = 1'b0; rd_en8 = 1'b0; rd_addr8 = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_rv", rv2, 0);
        chk("rst_rd_hit", rd_hit2, 0);
        chk("rst_rd_data", rd_data2, 0);
        chk("rst_c_lo", c2[63:0], 0);
        chk("rst_c_hi", c2[127:64], 0);
        rst = 1'b1;
        @(negedge clk);

        // Identity times B
        run2(32'h01_00_00_01, 32'h06_05_04_03, 1'b0);
        chk("ident_c_lo", c2[63:0], 64'h00000004_00000003);
        chk("ident_c_hi", c2[127:64], 64'h00000006_00000005);

        // Read window bounds (OFFSET=0x100, 4 elements)
        rd2(10'h0FC, 1'b1, 32'd0, 1'b0, "rd_below");
        rd2(10'h100, 1'b1, 32'd3, 1'b1, "rd_first");
        rd2(10'h104, 1'b1, 32'd4, 1'b1, "rd_second");
        rd2(10'h10C, 1'b1, 32'd6, 1'b1, "rd_last");
        rd2(10'h110, 1'b1, 32'd0, 1'b0, "rd_above");
        rd2(10'h100, 1'b0, 32'd0, 1'b0, "rd_disabled");

        // Snapshot isolation and ignored mid-CALC start
        run2(32'h04_03_02_01, 32'h08_07_06_05, 1'b1);
        chk("snap_c00", c2[31:0], 19);
        chk("snap_c11", c2[127:96], 50);
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done2 || busy2) pulses++;
        end
        chk("snap_no_rerun", pulses, 0);

        // Back-to-back random runs
        for (int n = 0; n < 4; n++) begin
            run2($urandom, $urandom, 1'b0);
        end

        // Reset mid-CALC
        a2 = 32'hFFFF_FFFF;
        b2 = 32'hFFFF_FFFF;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy2, 0);
        chk("abort_done", done2, 0);
        chk("abort_rv", rv2, 0);
        chk("abort_c_lo", c2[63:0], 0);
        chk("abort_c_hi", c2[127:64], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done2 || busy2) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run2($urandom, $urandom, 1'b0);

        // N=8 saturating magnitude
        run8({512{1'b1}}, {512{1'b1}});
        for (int e = 0; e < 64; e++) begin
            chk($sformatf("sat_c8[%0d]", e), c8[32*e +: 32], 32'h0007F008);
        end
        rd_en8 = 1'b1;
        rd_addr8 = 10'h03C;
        @(negedge clk);
        rd_en8 = 1'b0;
        chk("sat_rd_data", rd_data8, 32'h0007F008);
        chk("sat_rd_hit", rd_hit8, 1);

        // N=8 random
        for (int w = 0; w < 16; w++) begin
            ra[32*w +: 32] = $urandom;
            rb[32*w +: 32] = $urandom;
        end
        run8(ra, rb);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("rnd_c8[%0d][%0d]", r, c), c8[32*(r*8+c) +: 32],
                    mref(ra, rb, 8, r, c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
- Consumes the two flattened operand matrices A and B produced by the bus-loaded input-matrix stores.
- On a start pulse, snapshots both operands and computes C = A x B with a single multiply-accumulate (MAC) unit, one product per cycle.
- Holds C for the bus side: a registered, memory-mapped read port returns one element per 32-bit word, and a flat output feeds wider consumers.

Parameters:
- BITS, 8, operand element width (unsigned).
- N, 8, matrix dimension (N x N).
- OUT_BITS, 32, result element width; must be <= 32.
- ADDR_WIDTH, 10, bus byte-address width.
- OFFSET, 0, byte base address of the result window.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_all  in  N*N*BITS  matrix A; element (r,c) at [BITS*(r*N+c) +: BITS].
- b_all  in  N*N*BITS  matrix B; same layout.
- start  in  1  request computation; sampled in IDLE only.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when C is complete.
- res_valid  out  1  C complete and stable.
- rd_en  in  1  bus read strobe.
- rd_addr  in  ADDR_WIDTH  bus byte address.
- rd_data  out  32  element read back, zero-extended.
- rd_hit  out  1  previous-cycle read was in range.
- c_all  out  N*N*OUT_BITS  flat C; element (r,c) at [OUT_BITS*(r*N+c) +: OUT_BITS].

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done, res_valid, rd_hit = 0; rd_data = 0; all C registers = 0; counters i, j, k = 0; accumulator = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 captures a_all and b_all into internal snapshot registers.
  - Clears i, j, k and the accumulator; sets res_valid=0; next state CALC.
  - start=0 keeps IDLE.
- CALC, each cycle:
  - acc_n = (k==0 ? 0 : acc) + A[i][k]*B[k][j], computed in OUT_BITS and truncated modulo 2^OUT_BITS.
  - When k==N-1: write C[i][j] = acc_n, set k=0, then advance j; on j==N-1, set j=0 and advance i.
  - Otherwise k++.
  - After the cycle with i=j=k=N-1, the next state is DONE.
- DONE: done=1 for exactly one cycle; res_valid=1; next state IDLE.
- Timing:
  - busy=1 in CALC only, so exactly N^3 cycles.
  - done is high on the (N^3+1)th cycle after the start edge.
- start while in CALC or DONE is ignored; there is no queueing.
- Changes to a_all or b_all after the start edge do not affect the result.
- C registers are overwritten progressively and are never cleared by start. c_all is always driven from them, so it shows partial results during CALC; consumers qualify it with res_valid.
- Read port:
  - Registered, latency 1.
  - Hit condition: rd_en=1 and OFFSET <= rd_addr < OFFSET + 4*N*N.
  - On a hit: element index = (rd_addr-OFFSET)>>2; rd_data = that element, zero-extended; rd_hit=1.
  - On a miss or rd_en=0: rd_data = 0, rd_hit=0.
  - Reads are allowed in any state and return current register contents.
- Reset during CALC aborts immediately: all outputs and C return to reset values, and no done pulse is issued.
- res_valid stays 1 from DONE until the next accepted start or reset.

Test Plan:
- Identity check (N=2): A = identity [1,0,0,1], B = [3,4,5,6], pulse start.
  - busy high for 8 cycles, then done on cycle 9.
  - C = [3,4,5,6]; c_all = 0x00000006_00000005_00000004_00000003.
- Saturation magnitude (N=8, BITS=8): every A and B element = 255.
  - Every C element = 8*65025 = 520200 (0x0007F008).
  - Read at rd_addr=OFFSET+0x3C (index 15): rd_data = 0x0007F008 one cycle later; rd_hit=1.
- Snapshot and ignored start (N=2): A=[1,2,3,4], B=[5,6,7,8], start; change A to all zeros on the next cycle, and pulse start again mid-CALC.
  - C = [19,22,43,50].
  - Exactly one done pulse; res_valid=1.
- Reset mid-operation: pulse rst low 3 cycles into CALC.
  - busy, done, res_valid immediately 0; c_all = 0.
  - No done pulse.
  - A subsequent start completes normally.
- Read-port bounds (N=2, OFFSET=0x100):
  - rd_addr 0x0FC -> rd_data 0, rd_hit 0.
  - rd_addr 0x100 -> C[0][0].
  - rd_addr 0x10C -> C[1][1].
  - rd_addr 0x110 -> rd_data 0, rd_hit 0.
  - rd_en=0 at 0x100 -> rd_data 0.
- Back-to-back runs: start immediately after done.
  - res_valid drops the cycle after start.
  - The second result replaces the first, with identical latency (N^3+1).
